psum_norm_div: RTL and testbench



---
 rtl/psum_norm_pkg.sv | 22 ++
 rtl/psum_norm_div_seq_udiv.sv | 78 +++++++
 rtl/psum_norm_div.sv | 236 +++++++++++++++++++++++
 tb/tb_psum_norm_div.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_norm_pkg.sv
// Shared types and sizing helpers for the per-batch psum normalizer.
package psum_norm_pkg;

    localparam int unsigned BW_DEF     = 20;
    localparam int unsigned SUM_BW_DEF = 24;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned FRAC_DEF   = 8;

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        SEND      = 3'd1,
        WAIT_PEER = 3'd2,
        DIVIDE    = 3'd3,
        HOLD      = 3'd4
    } state_e;

    // Dividend is |entry| shifted up by the fractional bits.
    function automatic int unsigned dividend_width(input int unsigned bw, input int unsigned frac);
        return bw + frac;
    endfunction

endpackage

// File: rtl/psum_norm_div_seq_udiv.sv
// Unsigned restoring divider, one quotient bit per clock.
// The load cycle already resolves the first bit, so a DW-bit divide
// finishes DW edges after start and raises done for one cycle.
module seq_udiv #(
    parameter int unsigned DW = 28,
    parameter int unsigned VW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int unsigned CW = $clog2(DW + 1);

    logic [DW-1:0] dq_q;
    logic [DW-1:0] dq_d;
    logic [DW-1:0] src_dq;
    logic [VW-1:0] rem_q;
    logic [VW-1:0] rem_d;
    logic [VW-1:0] src_rem;
    logic [VW-1:0] dvs_q;
    logic [VW-1:0] src_dvs;
    logic [VW:0]   trial;
    logic          ge;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    // One restoring step on either freshly loaded operands or the running state.
    always_comb begin
        src_dq  = start ? dividend : dq_q;
        src_rem = start ? '0 : rem_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem, src_dq[DW-1]};
        ge      = (trial >= {1'b0, src_dvs});
        rem_d   = ge ? VW'(trial - {1'b0, src_dvs}) : VW'(trial);
        dq_d    = {src_dq[DW-2:0], ge};
    end

    // Shift register holds remaining dividend bits on the left, quotient bits on the right.
    always_ff @(posedge clk) begin
        if (reset) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                dq_q   <= dq_d;
                rem_q  <= rem_d;
                dvs_q  <= divisor;
                cnt_q  <= CW'(DW - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                dq_q  <= dq_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = dq_q;

endmodule

// File: rtl/psum_norm_div.sv
// Per-batch psum normalizer: buffers a batch, exchanges absolute sums with
// the peer core, then streams each entry divided by the combined sum.
module psum_norm_div
    import psum_norm_pkg::*;
#(
    parameter int unsigned BW     = BW_DEF,
    parameter int unsigned SUM_BW = SUM_BW_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned FRAC   = FRAC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BW-1:0]     in,
    input  logic              wr,
    output logic              o_full,
    output logic [SUM_BW-1:0] sum_out,
    output logic              sum_valid,
    input  logic [SUM_BW-1:0] syncd_sum_in,
    input  logic              syncd_valid,
    output logic [2*BW-1:0]   out,
    output logic              out_valid,
    input  logic              div,
    output logic              o_ready
);

    localparam int unsigned DW = dividend_width(BW, FRAC);
    localparam int unsigned OW = 2 * BW;
    localparam int unsigned MW = BW + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [BW-1:0]     ent_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [SUM_BW-1:0] acc_q;
    logic [SUM_BW-1:0] acc_d;
    logic [SUM_BW-1:0] total_q;
    logic [SUM_BW-1:0] total_d;
    logic [SUM_BW-1:0] sum_out_q;
    logic [SUM_BW-1:0] sum_out_d;
    logic              sum_valid_q;
    logic              sum_valid_d;
    logic [OW-1:0]     out_q;
    logic [OW-1:0]     out_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              o_full_q;
    logic              o_full_d;
    logic              o_ready_q;
    logic              o_ready_d;

    logic              we_c;
    logic              start_c;
    logic [DW-1:0]     dvd_c;
    logic [OW-1:0]     q_ext_c;
    logic              wr_last_c;
    logic              rd_last_c;
    logic              div_busy;
    logic              div_done;
    logic [DW-1:0]     div_quot;

    // Magnitude of a signed psum; one extra bit keeps the most-negative value exact.
    function automatic logic [MW-1:0] mag_of(input logic [BW-1:0] v);
        logic [MW-1:0] ext;
        ext = {v[BW-1], v};
        return v[BW-1] ? (~ext + MW'(1)) : ext;
    endfunction

    assign wr_last_c = (wr_ptr_q == LAST);
    assign rd_last_c = (rd_ptr_q == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (wr && wr_last_c) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_PEER;
            end
            WAIT_PEER: begin
                if (syncd_valid) begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if ((total_q == '0) || div_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (div) begin
                    state_d = rd_last_c ? FILL : DIVIDE;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Datapath and registered-output next values; the divider is launched on
    // the edge that enters DIVIDE so back-to-back entries add no bubble.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        acc_d       = acc_q;
        total_d     = total_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = 1'b0;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        we_c        = 1'b0;
        start_c     = 1'b0;
        q_ext_c     = OW'(div_quot);
        case (state_q)
            FILL: begin
                if (wr) begin
                    we_c     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    acc_d    = acc_q + SUM_BW'(mag_of(in));
                    if (wr_last_c) begin
                        sum_out_d   = acc_d;
                        sum_valid_d = 1'b1;
                    end
                end
            end
            WAIT_PEER: begin
                if (syncd_valid) begin
                    total_d  = acc_q + syncd_sum_in;
                    rd_ptr_d = '0;
                    start_c  = (total_d != '0);
                end
            end
            DIVIDE: begin
                if (total_q == '0) begin
                    out_d       = '0;
                    out_valid_d = 1'b1;
                end else if (div_done) begin
                    out_d       = ent_q[rd_ptr_q][BW-1] ? (~q_ext_c + OW'(1)) : q_ext_c;
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (div) begin
                    out_valid_d = 1'b0;
                    if (rd_last_c) begin
                        acc_d    = '0;
                        wr_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        start_c  = (total_q != '0);
                    end
                end
            end
            default: begin
            end
        endcase
        start_c   = start_c && !div_busy;
        dvd_c     = DW'({mag_of(ent_q[rd_ptr_d]), {FRAC{1'b0}}});
        o_full_d  = (state_d != FILL);
        o_ready_d = (state_d == FILL) && (wr_ptr_d == '0);
    end

    // Control, sum and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            acc_q       <= '0;
            total_q     <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            o_full_q    <= 1'b0;
            o_ready_q   <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            acc_q       <= acc_d;
            total_q     <= total_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            o_full_q    <= o_full_d;
            o_ready_q   <= o_ready_d;
        end
    end

    // Batch buffer; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (we_c) begin
            ent_q[wr_ptr_q] <= in;
        end
    end

    seq_udiv #(
        .DW (DW),
        .VW (SUM_BW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .dividend (dvd_c),
        .divisor  (total_d),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign o_full    = o_full_q;
    assign sum_out   = sum_out_q;
    assign sum_valid = sum_valid_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign o_ready   = o_ready_q;

endmodule

// File: tb/tb_psum_norm_div.sv
// Scoreboard bench for psum_norm_div: a driver pushes expected sums and
// quotients computed with plain arithmetic; a negedge monitor pops and compares.
module tb_psum_norm_div;

    localparam int BW     = 20;
    localparam int SUM_BW = 24;
    localparam int DEPTH  = 8;
    localparam int FRAC   = 8;
    localparam int DIV_LAT  = BW + FRAC + 1;
    localparam int ZERO_LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BW-1:0]     psum_in = '0;
    logic              wr = 1'b0;
    logic              o_full;
    logic [SUM_BW-1:0] sum_out;
    logic              sum_valid;
    logic [SUM_BW-1:0] peer_sum = '0;
    logic              syncd_valid = 1'b0;
    logic [2*BW-1:0]   q_out;
    logic              out_valid;
    logic              div = 1'b0;
    logic              o_ready;

    always #5 clk = ~clk;

    psum_norm_div #(
        .BW(BW), .SUM_BW(SUM_BW), .DEPTH(DEPTH), .FRAC(FRAC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (psum_in),
        .wr           (wr),
        .o_full       (o_full),
        .sum_out      (sum_out),
        .sum_valid    (sum_valid),
        .syncd_sum_in (peer_sum),
        .syncd_valid  (syncd_valid),
        .out          (q_out),
        .out_valid    (out_valid),
        .div          (div),
        .o_ready      (o_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    longint exp_sum_q[$];
    longint exp_out_q[$];
    int exp_sv_cyc = 0;
    int exp_lat = 0;
    int evt_cyc = 0;
    int xfer_cnt = 0;
    bit real_sync = 1'b0;
    int ents[DEPTH];

    bit              prev_ov = 1'b0;
    bit              prev_xfer = 1'b0;
    logic [2*BW-1:0] prev_out = '0;
    longint          m_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint iabs(input int v);
        return (v < 0) ? -longint'(v) : longint'(v);
    endfunction

    // Monitor: compares every sum pulse and every output transfer against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov   = 1'b0;
                prev_xfer = 1'b0;
            end else begin
                if (syncd_valid && real_sync) evt_cyc = cyc;
                if (sum_valid) begin
                    if (exp_sum_q.size() == 0) begin
                        chk(1'b0, "unexpected_sum_valid", longint'(sum_out), -1);
                    end else begin
                        m_exp = exp_sum_q.pop_front();
                        chk(longint'(sum_out) == m_exp, "sum_out", longint'(sum_out), m_exp);
                        chk(cyc == exp_sv_cyc, "sum_valid_cycle", cyc, exp_sv_cyc);
                    end
                end
                if (prev_ov && !prev_xfer) begin
                    chk(out_valid && (q_out == prev_out), "hold_stable",
                        longint'($signed(q_out)), longint'($signed(prev_out)));
                end else if (out_valid && !prev_ov) begin
                    chk((cyc - evt_cyc) == exp_lat, "out_latency", cyc - evt_cyc, exp_lat);
                end
                if (out_valid && div) begin
                    if (exp_out_q.size() == 0) begin
                        chk(1'b0, "unexpected_out", longint'($signed(q_out)), -1);
                    end else begin
                        m_exp = exp_out_q.pop_front();
                        chk(longint'($signed(q_out)) == m_exp, "out_value",
                            longint'($signed(q_out)), m_exp);
                    end
                    evt_cyc = cyc;
                    xfer_cnt++;
                end
                prev_ov   = out_valid;
                prev_xfer = out_valid && div;
                prev_out  = q_out;
            end
        end
    end

    // Drive one batch from ents[]; optionally stall the first output or reset mid-divide.
    task automatic run_batch(input int peer, input bit rand_div, input int hold_cyc,
                             input int reset_entry, input bit spurious);
        longint sum;
        longint total;
        longint q;
        int     base;
        int     budget;
        bit     held;
        budget = 0;
        while (!o_ready && budget < 100) begin
            tick();
            budget++;
        end
        chk(o_ready, "o_ready_before_batch", o_ready, 1);
        sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += iabs(ents[i]);
        total = (sum + longint'(peer)) % (longint'(1) << SUM_BW);
        exp_sum_q.push_back(sum);
        for (int i = 0; i < DEPTH; i++) begin
            q = (total == 0) ? 0 : ((iabs(ents[i]) << FRAC) / total);
            exp_out_q.push_back((ents[i] < 0) ? -q : q);
        end
        exp_lat = (total == 0) ? ZERO_LAT : DIV_LAT;
        base = xfer_cnt;

        for (int i = 0; i < DEPTH; i++) begin
            if (rand_div) repeat ($urandom_range(0, 2)) tick();
            wr      = 1'b1;
            psum_in = BW'(ents[i]);
            if (spurious && i == 1) begin
                syncd_valid = 1'b1;
                peer_sum    = SUM_BW'($urandom);
            end
            if (i == DEPTH - 1) exp_sv_cyc = cyc + 1;
            tick();
            wr          = 1'b0;
            syncd_valid = 1'b0;
        end
        chk(o_full, "o_full_after_fill", o_full, 1);
        tick();
        repeat ($urandom_range(0, 3)) tick();
        syncd_valid = 1'b1;
        peer_sum    = SUM_BW'(peer);
        real_sync   = 1'b1;
        tick();
        syncd_valid = 1'b0;
        real_sync   = 1'b0;

        budget = 0;
        held   = 1'b0;
        while (xfer_cnt < base + DEPTH && budget < 3000) begin
            if (reset_entry >= 0 && xfer_cnt == base + reset_entry) begin
                div = 1'b0;
                repeat (10) tick();
                reset = 1'b1;
                tick();
                chk(!out_valid, "rst_mid_out_valid", out_valid, 0);
                chk(o_ready, "rst_mid_o_ready", o_ready, 1);
                chk(sum_out == '0, "rst_mid_sum_out", longint'(sum_out), 0);
                chk(!o_full, "rst_mid_o_full", o_full, 0);
                reset = 1'b0;
                exp_out_q.delete();
                return;
            end
            if (hold_cyc > 0 && !held && out_valid) begin
                held = 1'b1;
                div  = 1'b0;
                for (int k = 0; k < hold_cyc; k++) begin
                    if (k % 10 == 5) begin
                        chk(o_full, "o_full_in_hold", o_full, 1);
                        wr      = 1'b1;
                        psum_in = BW'($urandom);
                    end else begin
                        wr = 1'b0;
                    end
                    tick();
                end
                wr = 1'b0;
            end
            div = rand_div ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            budget++;
        end
        chk(xfer_cnt == base + DEPTH, "batch_drained", xfer_cnt - base, DEPTH);
        div = 1'b0;
    endtask

    task automatic rand_ents();
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0)
                ents[i] = int'($urandom_range(0, 200)) - 100;
            else
                ents[i] = int'($urandom_range(0, (1 << BW) - 1)) - (1 << (BW - 1));
        end
    endtask

    initial begin
        repeat (3) tick();
        chk(!o_full, "rst_o_full", o_full, 0);
        chk(sum_out == '0, "rst_sum_out", longint'(sum_out), 0);
        chk(!sum_valid, "rst_sum_valid", sum_valid, 0);
        chk(q_out == '0, "rst_out", longint'($signed(q_out)), 0);
        chk(!out_valid, "rst_out_valid", out_valid, 0);
        chk(o_ready, "rst_o_ready", o_ready, 1);
        reset = 1'b0;
        tick();

        ents = '{100, 100, 100, 100, 100, 100, 100, 100};
        run_batch(224, 1'b0, 0, -1, 1'b1);

        ents = '{-512, 512, 0, 0, 0, 0, 0, 0};
        run_batch(0, 1'b0, 0, -1, 1'b0);

        ents = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_batch(0, 1'b0, 0, -1, 1'b0);

        rand_ents();
        run_batch(int'($urandom_range(0, 1 << 22)), 1'b0, 50, -1, 1'b0);

        rand_ents();
        run_batch(int'($urandom_range(0, 1 << 22)), 1'b0, 0, 3, 1'b0);

        ents = '{-(1 << (BW - 1)), 0, 0, 0, 0, 0, 0, 0};
        run_batch(0, 1'b0, 0, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_ents();
            run_batch(int'($urandom_range(0, 1 << 22)), 1'(r % 2), 0, -1, 1'(r == 2));
        end

        repeat (5) tick();
        chk(exp_sum_q.size() == 0, "sum_queue_empty", exp_sum_q.size(), 0);
        chk(exp_out_q.size() == 0, "out_queue_empty", exp_out_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles want fewer", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
